// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: physical address, cacheline,
// request source IDs and the arbiter state encoding.
package mem_arbiter_pkg;

  localparam int PADDR_W   = 32;
  localparam int LINE_W    = 64;
  localparam int n_threads = 2;

  typedef logic [PADDR_W-1:0] pptr_t;
  typedef logic [LINE_W-1:0]  cacheline_t;

  typedef enum logic {SRC_IC = 1'b0, SRC_DC = 1'b1} mem_src_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} arb_state_t;

  typedef struct packed {
    logic       we;
    pptr_t      addr;
    cacheline_t wdata;
  } dc_req_t;

  function automatic mem_src_t other_src(input mem_src_t s);
    return (s == SRC_IC) ? SRC_DC : SRC_IC;
  endfunction

endpackage

// File: rtl/mem_arbiter_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache request queues onto a single
// memory port, with in-order read response routing via a source-tag FIFO.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int QDEPTH    = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ic_req_ren,
  input  pptr_t      ic_req_addr,
  output logic       ic_rec_en,
  output pptr_t      ic_rec_addr,
  output cacheline_t ic_rec_cacheline,
  input  logic       dc_req_ren,
  input  logic       dc_req_wen,
  input  pptr_t      dc_req_addr,
  input  cacheline_t dc_req_wdata,
  output logic       dc_rec_en,
  output pptr_t      dc_rec_addr,
  output cacheline_t dc_rec_cacheline,
  output logic       mem_valid,
  output logic       mem_we,
  output pptr_t      mem_addr,
  output cacheline_t mem_wdata,
  input  logic       mem_ready,
  input  logic       mem_resp_valid,
  input  pptr_t      mem_resp_addr,
  input  cacheline_t mem_resp_data,
  output logic       ovf
);
  localparam int QCW = $clog2(QDEPTH) + 1;
  localparam int TCW = $clog2(MAX_OUTST) + 1;

  arb_state_t r_state, w_state_next;
  mem_src_t   r_prio, r_mem_src, w_load_src;
  logic       r_mem_we, r_ic_rec_en, r_dc_rec_en, r_ovf;
  pptr_t      r_mem_addr, r_rec_addr;
  cacheline_t r_mem_wdata, r_rec_line;
  logic       w_load, w_hs, w_ic_elig, w_dc_elig, w_read_ok, w_rd_inflight;

  logic       w_ic_full, w_ic_empty, w_ic_pop, w_ic_avail, w_ic_drop;
  pptr_t      w_ic_head, w_ic_cand_addr;
  logic [QCW-1:0] w_ic_count_unused, w_dc_count_unused;
  logic       w_dc_full, w_dc_empty, w_dc_pop, w_dc_push, w_dc_avail, w_dc_drop;
  dc_req_t    w_dc_in, w_dc_head, w_dc_cand;
  logic       w_tag_push, w_tag_pop, w_tag_empty, w_tag_full_unused;
  logic [0:0] w_tag_din, w_tag_head;
  logic [TCW-1:0] w_tag_count;
  logic [TCW:0]   w_outst;

  assign w_hs      = (r_state == ST_ISSUE) && mem_ready;
  assign w_ic_pop  = w_hs && (r_mem_src == SRC_IC);
  assign w_dc_pop  = w_hs && (r_mem_src == SRC_DC);
  assign w_dc_push = dc_req_ren || dc_req_wen;
  assign w_dc_in   = {dc_req_wen, dc_req_addr, dc_req_wdata};
  assign w_ic_drop = ic_req_ren && w_ic_full && !w_ic_pop;
  assign w_dc_drop = w_dc_push && w_dc_full && !w_dc_pop;

  sync_fifo #(.WIDTH($bits(pptr_t)), .DEPTH(QDEPTH)) u_ic_q (
    .clk(clk), .rst(rst), .push(ic_req_ren), .din(ic_req_addr), .pop(w_ic_pop),
    .dout(w_ic_head), .full(w_ic_full), .empty(w_ic_empty), .count(w_ic_count_unused));

  sync_fifo #(.WIDTH($bits(dc_req_t)), .DEPTH(QDEPTH)) u_dc_q (
    .clk(clk), .rst(rst), .push(w_dc_push), .din(w_dc_in), .pop(w_dc_pop),
    .dout(w_dc_head), .full(w_dc_full), .empty(w_dc_empty), .count(w_dc_count_unused));

  assign w_tag_push = w_hs && !r_mem_we;
  assign w_tag_din  = r_mem_src;
  assign w_tag_pop  = mem_resp_valid && !w_tag_empty;

  sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTST)) u_tag_q (
    .clk(clk), .rst(rst), .push(w_tag_push), .din(w_tag_din), .pop(w_tag_pop),
    .dout(w_tag_head), .full(w_tag_full_unused), .empty(w_tag_empty), .count(w_tag_count));

  // A read still sitting on the port counts as outstanding; a response popping now frees a slot.
  assign w_rd_inflight = (r_state == ST_ISSUE) && !r_mem_we;
  assign w_outst   = {1'b0, w_tag_count} + {{TCW{1'b0}}, w_rd_inflight} - {{TCW{1'b0}}, w_tag_pop};
  assign w_read_ok = w_outst < (TCW+1)'(MAX_OUTST);

  // An empty queue forwards the same-cycle pulse so an idle arbiter issues one cycle later.
  assign w_ic_avail     = !w_ic_empty || ic_req_ren;
  assign w_ic_cand_addr = w_ic_empty ? ic_req_addr : w_ic_head;
  assign w_dc_avail     = !w_dc_empty || w_dc_push;
  assign w_dc_cand      = w_dc_empty ? w_dc_in : w_dc_head;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_load) w_state_next = ST_ISSUE;
      ST_ISSUE: if (w_hs && !w_load) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // The issuing queue keeps its head until the handshake edge, so only the other queue may follow back-to-back.
  always_comb begin
    w_ic_elig  = 1'b0;
    w_dc_elig  = 1'b0;
    w_load     = 1'b0;
    w_load_src = r_prio;
    if (r_state == ST_IDLE) begin
      w_ic_elig = w_ic_avail && w_read_ok;
      w_dc_elig = w_dc_avail && (w_dc_cand.we || w_read_ok);
    end else if (w_hs) begin
      w_ic_elig = (r_mem_src == SRC_DC) && w_ic_avail && w_read_ok;
      w_dc_elig = (r_mem_src == SRC_IC) && w_dc_avail && (w_dc_cand.we || w_read_ok);
    end
    if (w_ic_elig && w_dc_elig) begin
      w_load = 1'b1;
    end else if (w_ic_elig || w_dc_elig) begin
      w_load     = 1'b1;
      w_load_src = w_ic_elig ? SRC_IC : SRC_DC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= SRC_IC;
      r_mem_src   <= SRC_IC;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_load) begin
      r_mem_src <= w_load_src;
      r_prio    <= other_src(w_load_src);
      if (w_load_src == SRC_IC) begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= w_ic_cand_addr;
        r_mem_wdata <= '0;
      end else begin
        r_mem_we    <= w_dc_cand.we;
        r_mem_addr  <= w_dc_cand.addr;
        r_mem_wdata <= w_dc_cand.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ic_rec_en <= 1'b0;
      r_dc_rec_en <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ic_rec_en <= w_tag_pop && (mem_src_t'(w_tag_head) == SRC_IC);
      r_dc_rec_en <= w_tag_pop && (mem_src_t'(w_tag_head) == SRC_DC);
      if (w_ic_drop || w_dc_drop || (mem_resp_valid && w_tag_empty)) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tag_pop) begin
      r_rec_addr <= mem_resp_addr;
      r_rec_line <= mem_resp_data;
    end
  end

  assign mem_valid        = (r_state == ST_ISSUE);
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign ic_rec_en        = r_ic_rec_en;
  assign ic_rec_addr      = r_rec_addr;
  assign ic_rec_cacheline = r_rec_line;
  assign dc_rec_en        = r_dc_rec_en;
  assign dc_rec_addr      = r_rec_addr;
  assign dc_rec_cacheline = r_rec_line;
  assign ovf              = r_ovf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the request queues, in-order memory and response routing.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int QDEPTH    = 4;
  localparam int MAX_OUTST = 8;

  logic       clk, rst;
  logic       ic_req_ren, ic_rec_en, dc_req_ren, dc_req_wen, dc_rec_en;
  pptr_t      ic_req_addr, ic_rec_addr, dc_req_addr, dc_rec_addr, mem_addr, mem_resp_addr;
  cacheline_t ic_rec_cacheline, dc_req_wdata, dc_rec_cacheline, mem_wdata, mem_resp_data;
  logic       mem_valid, mem_we, mem_ready, mem_resp_valid, ovf;

  mem_arbiter #(.QDEPTH(QDEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .ic_req_ren(ic_req_ren), .ic_req_addr(ic_req_addr),
    .ic_rec_en(ic_rec_en), .ic_rec_addr(ic_rec_addr), .ic_rec_cacheline(ic_rec_cacheline),
    .dc_req_ren(dc_req_ren), .dc_req_wen(dc_req_wen), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata),
    .dc_rec_en(dc_rec_en), .dc_rec_addr(dc_rec_addr), .dc_rec_cacheline(dc_rec_cacheline),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_addr(mem_resp_addr), .mem_resp_data(mem_resp_data),
    .ovf(ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cacheline_t line_of(input pptr_t a);
    return {a ^ 32'hC0DE_F00D, ~a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_ren = 0; ic_req_addr = '0;
    dc_req_ren = 0; dc_req_wen = 0; dc_req_addr = '0; dc_req_wdata = '0;
    mem_ready = 0; mem_resp_valid = 0; mem_resp_addr = '0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic respond(input pptr_t a);
    mem_resp_valid = 1'b1; mem_resp_addr = a; mem_resp_data = line_of(a);
    step();
    mem_resp_valid = 1'b0;
  endtask

  // ---------------- randomized model state ----------------
  typedef struct { logic we; pptr_t addr; cacheline_t wdata; } req_t;
  typedef struct { pptr_t addr; int ready_at; } pend_t;
  req_t  ic_q[$], dc_q[$], cur;
  pend_t pend_q[$];
  int    cyc, last_ready;
  bit    have_cur, cur_dc, cur_bogus;
  logic  exp_ic_en, exp_dc_en;
  pptr_t exp_addr;

  task automatic rand_cycle(input bit allow_pulse);
    pend_t p;
    pptr_t a;
    int    r;
    check("ic_rec_en", ic_rec_en, exp_ic_en);
    check("dc_rec_en", dc_rec_en, exp_dc_en);
    if (exp_ic_en) begin
      check("ic_rec_addr", ic_rec_addr, exp_addr);
      check("ic_rec_line", ic_rec_cacheline, line_of(exp_addr));
    end
    if (exp_dc_en) begin
      check("dc_rec_addr", dc_rec_addr, exp_addr);
      check("dc_rec_line", dc_rec_cacheline, line_of(exp_addr));
    end
    mem_ready = ($urandom_range(0, 3) != 0);
    if (mem_valid) begin
      if (!have_cur) begin
        cur_bogus = 0;
        if (mem_addr[31:28] == 4'h1 && ic_q.size() != 0) begin cur = ic_q[0]; cur_dc = 0; end
        else if (dc_q.size() != 0) begin cur = dc_q[0]; cur_dc = 1; end
        else begin cur = '{we: 1'b1, addr: '0, wdata: '0}; cur_dc = 0; cur_bogus = 1; end
        if (!cur.we) check("read_limit", pend_q.size() < MAX_OUTST, 1'b1);
        have_cur = 1;
      end
      check("issue_we", mem_we, cur.we);
      check("issue_addr", mem_addr, cur.addr);
      if (cur.we) check("issue_wdata", mem_wdata, cur.wdata);
      if (mem_ready) begin
        if (!cur_bogus) begin
          if (cur_dc) void'(dc_q.pop_front()); else void'(ic_q.pop_front());
        end
        if (!cur.we) begin
          r = cyc + $urandom_range(1, 8);
          if (r <= last_ready) r = last_ready + 1;
          last_ready = r;
          pend_q.push_back('{addr: cur.addr, ready_at: r});
        end
        have_cur = 0;
      end
    end else if (have_cur) begin
      check("issue_held", mem_valid, 1'b1);
      have_cur = 0;
    end
    exp_ic_en = 0; exp_dc_en = 0; mem_resp_valid = 0;
    if (pend_q.size() != 0 && pend_q[0].ready_at <= cyc && $urandom_range(0, 1) == 1) begin
      p = pend_q.pop_front();
      mem_resp_valid = 1; mem_resp_addr = p.addr; mem_resp_data = line_of(p.addr);
      exp_addr = p.addr;
      if (p.addr[31:28] == 4'h1) exp_ic_en = 1; else exp_dc_en = 1;
    end
    ic_req_ren = 0; dc_req_ren = 0; dc_req_wen = 0;
    if (allow_pulse && ic_q.size() < QDEPTH && $urandom_range(0, 2) == 0) begin
      a = {4'h1, 22'($urandom), 6'b0};
      ic_req_ren = 1; ic_req_addr = a;
      ic_q.push_back('{we: 1'b0, addr: a, wdata: '0});
    end
    r = $urandom_range(0, 5);
    if (allow_pulse && dc_q.size() < QDEPTH && r < 2) begin
      a = {4'h2, 22'($urandom), 6'b0};
      dc_req_addr = a;
      dc_req_wdata = {$urandom, $urandom};
      if (r == 0) dc_req_ren = 1; else dc_req_wen = 1;
      dc_q.push_back('{we: (r == 1), addr: a, wdata: dc_req_wdata});
    end
    step();
    cyc++;
  endtask

  pptr_t got_q[$];

  initial begin
    rst = 1'b1;
    do_reset();
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_ic_rec_en", ic_rec_en, 1'b0);
    check("rst_dc_rec_en", dc_rec_en, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    // single icache read, one-cycle issue latency, response routed back
    mem_ready = 1; ic_req_ren = 1; ic_req_addr = 32'h100;
    step();
    ic_req_ren = 0;
    check("t31_valid", mem_valid, 1'b1);
    check("t31_addr", mem_addr, 32'h100);
    check("t31_we", mem_we, 1'b0);
    step();
    check("t31_idle", mem_valid, 1'b0);
    repeat (3) step();
    respond(32'h100);
    check("t31_ic_en", ic_rec_en, 1'b1);
    check("t31_dc_en", dc_rec_en, 1'b0);
    check("t31_addr_back", ic_rec_addr, 32'h100);
    check("t31_line", ic_rec_cacheline, line_of(32'h100));
    step();
    check("t31_pulse", ic_rec_en, 1'b0);

    // simultaneous ic/dc reads: icache first after reset
    do_reset();
    mem_ready = 1;
    ic_req_ren = 1; ic_req_addr = 32'h1000_0080;
    dc_req_ren = 1; dc_req_addr = 32'h2000_00C0;
    step();
    ic_req_ren = 0; dc_req_ren = 0;
    check("t32_first", mem_addr, 32'h1000_0080);
    check("t32_first_v", mem_valid, 1'b1);
    step();
    check("t32_second", mem_addr, 32'h2000_00C0);
    check("t32_second_v", mem_valid, 1'b1);
    check("t32_second_we", mem_we, 1'b0);
    step();
    check("t32_idle", mem_valid, 1'b0);
    respond(32'h1000_0080);
    check("t32_ic_en", ic_rec_en, 1'b1);
    check("t32_dc_en0", dc_rec_en, 1'b0);
    respond(32'h2000_00C0);
    check("t32_dc_en", dc_rec_en, 1'b1);
    check("t32_ic_en0", ic_rec_en, 1'b0);
    check("t32_dc_addr", dc_rec_addr, 32'h2000_00C0);

    // write held under backpressure, produces no response
    do_reset();
    dc_req_wen = 1; dc_req_addr = 32'h40; dc_req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
    step();
    dc_req_wen = 0;
    for (int i = 0; i < 4; i++) begin
      check("t33_valid", mem_valid, 1'b1);
      check("t33_we", mem_we, 1'b1);
      check("t33_addr", mem_addr, 32'h40);
      check("t33_wdata", mem_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
      if (i == 3) mem_ready = 1;
      step();
    end
    mem_ready = 0;
    check("t33_done", mem_valid, 1'b0);
    respond(32'h40);
    check("t33_no_dc", dc_rec_en, 1'b0);
    check("t33_no_ic", ic_rec_en, 1'b0);
    check("t33_ovf", ovf, 1'b1);

    // queue overflow: fifth pulse dropped, ovf sticky until reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ic_req_ren = 1; ic_req_addr = 32'h1000_0200 + 32'(i * 64);
      step();
      check("t34_ovf", ovf, (i == 4));
    end
    ic_req_ren = 0;
    mem_ready = 1;
    got_q.delete();
    for (int k = 0; k < 20; k++) begin
      if (mem_valid) got_q.push_back(mem_addr);
      step();
    end
    check("t34_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("t34_order", got_q[i], 32'h1000_0200 + 32'(i * 64));
    check("t34_ovf_sticky", ovf, 1'b1);
    do_reset();
    check("t34_ovf_clr", ovf, 1'b0);

    // outstanding-read limit
    mem_ready = 1;
    for (int i = 0; i < MAX_OUTST; i++) begin
      ic_req_ren = 1; ic_req_addr = 32'h1000_0000 + 32'(i * 64);
      step();
      ic_req_ren = 0;
      check("t35_issue", mem_valid, 1'b1);
      step();
    end
    ic_req_ren = 1; ic_req_addr = 32'h1000_0900;
    step();
    ic_req_ren = 0;
    for (int k = 0; k < 4; k++) begin
      check("t35_block", mem_valid, 1'b0);
      step();
    end
    respond(32'h1000_0000);
    check("t35_resp", ic_rec_en, 1'b1);
    check("t35_release", mem_valid, 1'b1);
    check("t35_addr", mem_addr, 32'h1000_0900);

    // reset mid-issue
    do_reset();
    ic_req_ren = 1; ic_req_addr = 32'h300;
    step();
    ic_req_ren = 0;
    check("t36_valid", mem_valid, 1'b1);
    rst = 1;
    step();
    rst = 0;
    check("t36_valid0", mem_valid, 1'b0);
    check("t36_ic0", ic_rec_en, 1'b0);
    check("t36_dc0", dc_rec_en, 1'b0);
    check("t36_ovf0", ovf, 1'b0);
    respond(32'h300);
    check("t36_no_rec", ic_rec_en, 1'b0);
    check("t36_ovf", ovf, 1'b1);
    step();
    check("t36_dropped", mem_valid, 1'b0);

    // randomized traffic
    do_reset();
    ic_q.delete(); dc_q.delete(); pend_q.delete();
    cyc = 0; last_ready = 0; have_cur = 0; exp_ic_en = 0; exp_dc_en = 0; exp_addr = '0;
    for (int k = 0; k < 3000; k++) rand_cycle(1'b1);
    for (int k = 0; k < 400; k++) begin
      if (ic_q.size() == 0 && dc_q.size() == 0 && pend_q.size() == 0) break;
      rand_cycle(1'b0);
    end
    rand_cycle(1'b0);
    check("drain", ic_q.size() + dc_q.size() + pend_q.size(), 0);
    check("rand_ovf", ovf, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
